regfile_arbiter: RTL

//  Shares the single-port register file (RdEn/WrEn/Address/WrData -> RdData, 1-cycle registered read) between two requesters.

---
 rtl/regfile_arbiter_pkg.sv | 16 +
 rtl/regfile_arbiter_if.sv | 40 ++++
 rtl/regfile_arbiter_rr.sv | 25 ++
 rtl/regfile_arbiter.sv | 114 +++++++++++
 4 files changed

// File: rtl/regfile_arbiter_pkg.sv
// Shared types for the two-requester register file arbiter.
// State encoding, requester id and requester count.
package regfile_arb_pkg;

   localparam int NUM_REQ = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      READ  = 2'd2,
      RESP  = 2'd3
   } state_t;

   typedef logic id_t;

endpackage

// File: rtl/regfile_arbiter_if.sv
// Requester-side bundle for the register file arbiter.
// Two identical req/gnt/done/valid sets, one per requester.
interface regfile_arbiter_if #(
   parameter int WIDTH = 16,
   parameter int AddrW = 3
);

   logic             Req0;
   logic             Wr0;
   logic [AddrW-1:0] Addr0;
   logic [WIDTH-1:0] WrData0;
   logic             Gnt0;
   logic             Done0;
   logic             RdValid0;
   logic [WIDTH-1:0] RdData0;

   logic             Req1;
   logic             Wr1;
   logic [AddrW-1:0] Addr1;
   logic [WIDTH-1:0] WrData1;
   logic             Gnt1;
   logic             Done1;
   logic             RdValid1;
   logic [WIDTH-1:0] RdData1;

   modport master (
      output Req0, Wr0, Addr0, WrData0,
      input  Gnt0, Done0, RdValid0, RdData0,
      output Req1, Wr1, Addr1, WrData1,
      input  Gnt1, Done1, RdValid1, RdData1
   );

   modport slave (
      input  Req0, Wr0, Addr0, WrData0,
      output Gnt0, Done0, RdValid0, RdData0,
      input  Req1, Wr1, Addr1, WrData1,
      output Gnt1, Done1, RdValid1, RdData1
   );

endinterface

// File: rtl/regfile_arbiter_rr.sv
// Two-way round-robin grant, purely combinational.
// On a tie the id not granted last time wins.
module rr_arbiter_2
   import regfile_arb_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  id_t                last,
   input  logic               en,
   output logic [NUM_REQ-1:0] gnt
);

   // One-hot grant; a lone requester wins regardless of the pointer
   always_comb begin
      gnt = '0;
      if (en) begin
         unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = '0;
         endcase
      end
   end

endmodule

// File: rtl/regfile_arbiter.sv
// Shares a single-port register file between two requesters.
// One transaction in flight; writes take 2 cycles, reads 3.
module regfile_arbiter
   import regfile_arb_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int AddrW = 3
) (
   input  logic             CLK,
   input  logic             RST,
   regfile_arbiter_if.slave bus,
   output logic             RfRdEn,
   output logic             RfWrEn,
   output logic [AddrW-1:0] RfAddr,
   output logic [WIDTH-1:0] RfWrData,
   input  logic [WIDTH-1:0] RfRdData
);

   state_t               state;
   state_t               state_nxt;
   id_t                  owner;
   id_t                  ptr;
   logic [AddrW-1:0]     own_addr;
   logic [WIDTH-1:0]     own_data;
   logic [NUM_REQ-1:0]   req;
   logic [NUM_REQ-1:0]   gnt;
   logic [NUM_REQ-1:0]   done;
   logic [NUM_REQ-1:0]   vld;
   id_t                  win;
   logic                 win_wr;
   logic [AddrW-1:0]     win_addr;
   logic [WIDTH-1:0]     win_data;

   assign req = {bus.Req1, bus.Req0};

   rr_arbiter_2 u_rr (
      .req  (req),
      .last (ptr),
      .en   (state == IDLE),
      .gnt  (gnt)
   );

   assign win      = gnt[1];
   assign win_wr   = win ? bus.Wr1     : bus.Wr0;
   assign win_addr = win ? bus.Addr1   : bus.Addr0;
   assign win_data = win ? bus.WrData1 : bus.WrData0;

   // FSM state register
   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Owner, transaction and priority pointer capture on a grant
   always_ff @(posedge CLK) begin
      if (RST) begin
         owner    <= 1'b0;
         ptr      <= 1'b1;
         own_addr <= '0;
         own_data <= '0;
      end else if (|gnt) begin
         owner    <= win;
         ptr      <= win;
         own_addr <= win_addr;
         own_data <= win_data;
      end
   end

   // Next state and per-state regfile enables / completion pulses
   always_comb begin
      state_nxt = state;
      RfRdEn    = 1'b0;
      RfWrEn    = 1'b0;
      done      = '0;
      vld       = '0;
      unique case (state)
         IDLE: begin
            if (|gnt) begin
               state_nxt = win_wr ? WRITE : READ;
            end
         end
         WRITE: begin
            RfWrEn      = 1'b1;
            done[owner] = 1'b1;
            state_nxt   = IDLE;
         end
         READ: begin
            RfRdEn    = 1'b1;
            state_nxt = RESP;
         end
         RESP: begin
            vld[owner] = 1'b1;
            state_nxt  = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign RfAddr   = own_addr;
   assign RfWrData = own_data;

   assign bus.Gnt0     = gnt[0];
   assign bus.Gnt1     = gnt[1];
   assign bus.Done0    = done[0];
   assign bus.Done1    = done[1];
   assign bus.RdValid0 = vld[0];
   assign bus.RdValid1 = vld[1];
   assign bus.RdData0  = RfRdData;
   assign bus.RdData1  = RfRdData;

endmodule
